alpha_run_sequencer: RTL
========================

// Module: alpha_run_sequencer
// PURPOSE
//  Single FSM that sequences an ALPHA ASIC from power-up to triggered running.
//  - Drives the three power-up steps in order: startup_sequence_3, startup_sequence_2, start_i2c_transfer.
//  - Waits for an arm request, issues startup_sequence_1, then schedules periodic trigger pulses.
//  - Gates each trigger on readout completion or a timeout; keeps trigger and timeout counters.
//  Sits between the board-level button/registers and alpha_control; all outputs are registered.
// PARAMETERS
//  DELAY3_LOG2     26  cycles from reset release to startup_sequence_3 = 2**DELAY3_LOG2
//  DELAY2_LOG2     26  cycles from startup_sequence_3 to startup_sequence_2 = 2**DELAY2_LOG2
//  DELAYI2C_LOG2   26  cycles from startup_sequence_2 to start_i2c_transfer = 2**DELAYI2C_LOG2
//  PERIOD_WIDTH    24  width of trigger_period
//  TIMEOUT_LOG2    20  readout timeout = 2**TIMEOUT_LOG2 cycles
//  COUNT_WIDTH     16  width of trigger_count and timeout_count
// PORTS
//  clock               in   1   single clock; all logic on posedge
//  reset_n             in   1   asynchronous, active-low reset
//  arm                 in   1   1-cycle pulse (debounced button or register); used only in IDLE
//  abort               in   1   1-cycle pulse; returns the sequencer from WAIT_PERIOD/READOUT to IDLE
//  trigger_period      in   PERIOD_WIDTH  cycles between readout end and next trig; 0 = single-shot
//  readout_done        in   1   1-cycle pulse from the readout path; end of event
//  startup_sequence_3  out  1   1-cycle pulse
//  startup_sequence_2  out  1   1-cycle pulse
//  start_i2c_transfer  out  1   1-cycle pulse
//  startup_sequence_1  out  1   1-cycle pulse; issued on arm
//  trig                out  1   1-cycle trigger pulse to trig_top
//  ready               out  1   high in IDLE (init complete, not running)
//  running             out  1   high in WAIT_PERIOD or READOUT
//  state               out  3   current state encoding, for LEDs and debug
//  trigger_count       out  COUNT_WIDTH  readouts completed since arm; saturates at all-ones
//  timeout_count       out  COUNT_WIDTH  readout timeouts since arm; saturates at all-ones
// BEHAVIOUR
//  Reset (reset_n low, asynchronous)
//  - state = DLY3, all pulses 0, ready = 0, running = 0, both counts 0, internal counters 0.
//  States and encoding
//  - DLY3=0, DLY2=1, DLYI2C=2, IDLE=3, WAIT_PERIOD=4, READOUT=5; codes 6-7 go to IDLE on the next edge.
//  Power-up delays (DLY3, DLY2, DLYI2C)
//  - A free counter clears on each state entry.
//  - The state's pulse is high exactly 2**L cycles after entry, where L is that state's DELAY*_LOG2 parameter.
//  - Entry to DLY3 is the first edge after reset_n rises.
//  - The next state is entered together with the pulse.
//  - arm and abort are ignored in these states.
//  IDLE
//  - ready = 1.
//  - On arm: startup_sequence_1 is high on the next cycle, both counts clear, trigger_period is sampled, go to WAIT_PERIOD.
//  WAIT_PERIOD
//  - A down-counter is loaded with the sampled period P.
//  - trig is high exactly P cycles after entry, then go to READOUT.
//  - P=0 gives trig on the cycle after entry.
//  READOUT
//  - A timeout counter clears on entry.
//  - On readout_done: trigger_count+1.
//  - On 2**TIMEOUT_LOG2 cycles without readout_done: timeout_count+1.
//  - After either event: if P==0, go to IDLE; otherwise go to WAIT_PERIOD and resample trigger_period.
//  - readout_done and timeout in the same cycle: readout_done wins and timeout_count is unchanged.
//  - readout_done outside READOUT is ignored.
//  abort in WAIT_PERIOD or READOUT
//  - Go to IDLE next cycle with no further trig.
//  - A simultaneous readout_done is still counted.
//  - A pending trig in the same cycle is suppressed.
//  General rules
//  - Counts saturate at all-ones and never wrap.
//  - Pulses are mutually exclusive and never longer than 1 cycle.
//  - reset_n low mid-run aborts immediately; the full power-up sequence reruns after release.
// TESTING
//  (bench parameters: DELAY*_LOG2=4, TIMEOUT_LOG2=5, COUNT_WIDTH=4)
//  T1 Power-up: release reset_n, no arm
//     -> startup_sequence_3 at cycle 16, startup_sequence_2 at 32, start_i2c_transfer at 48.
//     -> ready=1 from cycle 48; arm pulsed at cycle 20 is ignored.
//  T2 Normal run: P=10, arm in IDLE
//     -> startup_sequence_1 on the next cycle; trig 10 cycles after WAIT_PERIOD entry.
//     -> readout_done 5 cycles later gives trigger_count=1; next trig 10 cycles after that.
//  T3 Timeout: no readout_done after trig
//     -> timeout_count=1 at 32 cycles; trigger_count unchanged; next trig after P cycles.
//  T4 Single-shot: P=0, arm, then readout_done
//     -> exactly one trig; back in IDLE with trigger_count=1.
//  T5 Contention and saturation:
//     -> readout_done on the timeout cycle gives trigger_count+1 and timeout_count+0.
//     -> abort with readout_done gives count+1 then IDLE.
//     -> 20 readouts give trigger_count=15.
//  T6 Reset mid-run: reset_n low during READOUT
//     -> all outputs 0 and state=0 immediately; after release T1 timing repeats exactly.

Source files
------------

// File: rtl/alpha_run_sequencer.sv
// Power-up and run sequencer for the ALPHA ASIC: timed startup pulses, arm, then
// periodic triggers gated by readout completion or timeout, with event counters.
module alpha_run_sequencer #(
  parameter int unsigned DELAY3_LOG2   = 26,
  parameter int unsigned DELAY2_LOG2   = 26,
  parameter int unsigned DELAYI2C_LOG2 = 26,
  parameter int unsigned PERIOD_WIDTH  = 24,
  parameter int unsigned TIMEOUT_LOG2  = 20,
  parameter int unsigned COUNT_WIDTH   = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    arm,
  input  logic                    abort,
  input  logic [PERIOD_WIDTH-1:0] trigger_period,
  input  logic                    readout_done,
  output logic                    startup_sequence_3,
  output logic                    startup_sequence_2,
  output logic                    start_i2c_transfer,
  output logic                    startup_sequence_1,
  output logic                    trig,
  output logic                    ready,
  output logic                    running,
  output logic [2:0]              state,
  output logic [COUNT_WIDTH-1:0]  trigger_count,
  output logic [COUNT_WIDTH-1:0]  timeout_count
);

  localparam int unsigned MAX_A = (DELAY3_LOG2 > DELAY2_LOG2) ? DELAY3_LOG2 : DELAY2_LOG2;
  localparam int unsigned MAX_B = (DELAYI2C_LOG2 > TIMEOUT_LOG2) ? DELAYI2C_LOG2 : TIMEOUT_LOG2;
  localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W = (MAX_C > 0) ? MAX_C : 1;

  // Terminal values: the event fires on the edge where the counter holds 2**L-1.
  localparam logic [CNT_W-1:0] TERM3   = CNT_W'((64'd1 << DELAY3_LOG2) - 64'd1);
  localparam logic [CNT_W-1:0] TERM2   = CNT_W'((64'd1 << DELAY2_LOG2) - 64'd1);
  localparam logic [CNT_W-1:0] TERMI2C = CNT_W'((64'd1 << DELAYI2C_LOG2) - 64'd1);
  localparam logic [CNT_W-1:0] TERMTO  = CNT_W'((64'd1 << TIMEOUT_LOG2) - 64'd1);

  typedef enum logic [2:0] {
    S_DLY3    = 3'd0,
    S_DLY2    = 3'd1,
    S_DLYI2C  = 3'd2,
    S_IDLE    = 3'd3,
    S_WAIT    = 3'd4,
    S_READOUT = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic                    started_q, started_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PERIOD_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [COUNT_WIDTH-1:0]  trig_cnt_d, tmo_cnt_d;
  logic                    seq3_d, seq2_d, i2c_d, seq1_d, trig_d, ready_d, running_d;
  logic                    timeout_hit;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  assign state       = state_q;
  assign timeout_hit = (cnt_q == TERMTO);

  // Next-state, counters and output pulses.
  always_comb begin
    state_d    = state_q;
    started_d  = 1'b1;
    cnt_d      = cnt_q + CNT_W'(1);
    wcnt_d     = wcnt_q;
    period_d   = period_q;
    trig_cnt_d = trigger_count;
    tmo_cnt_d  = timeout_count;
    seq3_d     = 1'b0;
    seq2_d     = 1'b0;
    i2c_d      = 1'b0;
    seq1_d     = 1'b0;
    trig_d     = 1'b0;

    case (state_q)
      S_DLY3: begin
        // First edge after reset release is the entry edge and clears the counter.
        if (!started_q) begin
          cnt_d = '0;
        end else if (cnt_q == TERM3) begin
          seq3_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_DLY2;
        end
      end
      S_DLY2: begin
        if (cnt_q == TERM2) begin
          seq2_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_DLYI2C;
        end
      end
      S_DLYI2C: begin
        if (cnt_q == TERMI2C) begin
          i2c_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (arm) begin
          seq1_d     = 1'b1;
          trig_cnt_d = '0;
          tmo_cnt_d  = '0;
          period_d   = trigger_period;
          wcnt_d     = trigger_period;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = '0;
        if (abort) begin
          state_d = S_IDLE;
        end else if (wcnt_q <= PERIOD_WIDTH'(1)) begin
          trig_d  = 1'b1;
          state_d = S_READOUT;
        end else begin
          wcnt_d = wcnt_q - PERIOD_WIDTH'(1);
        end
      end
      S_READOUT: begin
        // readout_done takes priority over a coincident timeout.
        if (readout_done) begin
          trig_cnt_d = sat_inc(trigger_count);
        end else if (timeout_hit) begin
          tmo_cnt_d = sat_inc(timeout_count);
        end
        if (abort) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (readout_done || timeout_hit) begin
          cnt_d = '0;
          if (period_q == '0) begin
            state_d = S_IDLE;
          end else begin
            period_d = trigger_period;
            wcnt_d   = trigger_period;
            state_d  = S_WAIT;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    ready_d   = (state_d == S_IDLE);
    running_d = (state_d == S_WAIT) || (state_d == S_READOUT);
  end

  // State, counter and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= S_DLY3;
      started_q          <= 1'b0;
      cnt_q              <= '0;
      wcnt_q             <= '0;
      period_q           <= '0;
      startup_sequence_3 <= 1'b0;
      startup_sequence_2 <= 1'b0;
      start_i2c_transfer <= 1'b0;
      startup_sequence_1 <= 1'b0;
      trig               <= 1'b0;
      ready              <= 1'b0;
      running            <= 1'b0;
      trigger_count      <= '0;
      timeout_count      <= '0;
    end else begin
      state_q            <= state_d;
      started_q          <= started_d;
      cnt_q              <= cnt_d;
      wcnt_q             <= wcnt_d;
      period_q           <= period_d;
      startup_sequence_3 <= seq3_d;
      startup_sequence_2 <= seq2_d;
      start_i2c_transfer <= i2c_d;
      startup_sequence_1 <= seq1_d;
      trig               <= trig_d;
      ready              <= ready_d;
      running            <= running_d;
      trigger_count      <= trig_cnt_d;
      timeout_count      <= tmo_cnt_d;
    end
  end

endmodule
